// File: rtl/cache_controller.sv
// cache_controller: 4-line direct-mapped, write-back / write-allocate cache
// controller sitting between a CPU request port and a single-cycle-latency
// main memory. Address split: index = endereco[1:0], tag = endereco[4:2].
// Optional feature macro: CACHE_CTRL_STATS_EN enables saturating hit/miss
// counters; when undefined both counter outputs are tied to zero.
module cache_controller #(
    parameter int LINES = 4
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       req_in,
    input  logic       wren_in,
    input  logic [4:0] endereco_in,
    input  logic [7:0] data_in,
    output logic       ready_out,
    output logic       done_out,
    output logic [7:0] q_out,
    output logic       hit_cache_out,
    output logic       mem_clken_out,
    output logic       mem_wren_out,
    output logic [4:0] mem_address_out,
    output logic [7:0] mem_data_out,
    input  logic [7:0] mem_q_in,
    output logic [7:0] hit_count_out,
    output logic [7:0] miss_count_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        FILL_WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    // Latched request and per-request miss flag
    logic       req_wren;
    logic [4:0] req_addr;
    logic [7:0] req_data;
    logic       miss_q;

    // Line storage
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [2:0]       tag_q  [LINES];
    logic [7:0]       data_q [LINES];

    logic [1:0] idx;
    logic [2:0] req_tag;
    logic       lookup_hit;
    logic       victim_dirty;

    assign idx          = req_addr[1:0];
    assign req_tag      = req_addr[4:2];
    assign lookup_hit   = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what keeps this combinational block from inferring latches.
    always_comb begin
        state_nxt       = state;
        ready_out       = 1'b0;
        done_out        = 1'b0;
        mem_clken_out   = 1'b0;
        mem_wren_out    = 1'b0;
        mem_address_out = 5'd0;
        mem_data_out    = 8'd0;
        unique case (state)
            IDLE: begin
                // Gated by reset so ready stays low while reset is held
                ready_out = reset_n_in;
                if (req_in) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (lookup_hit)        state_nxt = RESP;
                else if (victim_dirty) state_nxt = WRITEBACK;
                else                   state_nxt = FILL;
            end
            WRITEBACK: begin
                mem_clken_out   = 1'b1;
                mem_wren_out    = 1'b1;
                mem_address_out = {tag_q[idx], idx};
                mem_data_out    = data_q[idx];
                state_nxt       = FILL;
            end
            FILL: begin
                mem_clken_out   = 1'b1;
                mem_address_out = req_addr;
                state_nxt       = FILL_WAIT;
            end
            FILL_WAIT: state_nxt = LOOKUP;
            RESP: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // hit_cache_out is only meaningful during done_out, so it is gated by it
    assign hit_cache_out = done_out & ~miss_q;

    // Request latch, miss flag, read data and line valid/dirty bits
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            req_wren <= 1'b0;
            req_addr <= 5'd0;
            req_data <= 8'd0;
            miss_q   <= 1'b0;
            q_out    <= 8'd0;
            valid_q  <= '0;
            dirty_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_in) begin
                        req_wren <= wren_in;
                        req_addr <= endereco_in;
                        req_data <= data_in;
                        miss_q   <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        if (req_wren) dirty_q[idx] <= 1'b1;
                        else          q_out        <= data_q[idx];
                    end else begin
                        miss_q <= 1'b1;
                    end
                end
                FILL_WAIT: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Line tag/data payload
    // NOTE: tag and data arrays are deliberately not reset; valid_q gates
    // every use of them, and leaving them unreset lets them map to plain RAM.
    always_ff @(posedge clock_in) begin
        if (state == LOOKUP && lookup_hit && req_wren) begin
            data_q[idx] <= req_data;
        end else if (state == FILL_WAIT) begin
            data_q[idx] <= mem_q_in;
            tag_q[idx]  <= req_tag;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    // Saturating statistics, bumped once per completed request
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            hit_cnt  <= 8'd0;
            miss_cnt <= 8'd0;
        end else if (state == RESP) begin
            if (!miss_q) begin
                if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
            end else begin
                if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end

    assign hit_count_out  = hit_cnt;
    assign miss_count_out = miss_cnt;
`else
    assign hit_count_out  = 8'd0;
    assign miss_count_out = 8'd0;
`endif

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter LINES, default 4, meaning the number of direct-mapped cache lines; only 4 is supported (index = endereco[1:0], tag = endereco[4:2]).
REQ-002 SHALL have port clock_in, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port reset_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_in, input, 1 bit: CPU request strobe.
REQ-005 SHALL have port wren_in, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port endereco_in, input, 5 bits: request address.
REQ-007 SHALL have port data_in, input, 8 bits: write data.
REQ-008 SHALL have port ready_out, output, 1 bit: controller idle and able to accept a request.
REQ-009 SHALL have port done_out, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port q_out, output, 8 bits: read data, valid while done_out=1.
REQ-011 SHALL have port hit_cache_out, output, 1 bit: valid while done_out=1; 1 = the first lookup hit.
REQ-012 SHALL have ports mem_clken_out (output, 1), mem_wren_out (output, 1), mem_address_out (output, 5), mem_data_out (output, 8): main-memory control.
REQ-013 SHALL have port mem_q_in, input, 8 bits: main-memory read data, valid 1 cycle after a read with clken asserted.
REQ-014 SHALL have ports hit_count_out (output, 8) and miss_count_out (output, 8): statistics counters (see Configuration).

Function
REQ-015 SHALL implement a write-back, write-allocate cache; per line: valid, dirty, tag[2:0], data[7:0].
REQ-016 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, FILL, FILL_WAIT, RESP.
REQ-017 IDLE SHALL drive ready_out=1; when req_in=1, latch wren_in/endereco_in/data_in and go to LOOKUP; req_in SHALL be ignored in every other state.
REQ-018 LOOKUP on hit (valid and tag match) SHALL go to RESP: a read captures line data into q_out; a write stores the latched data and sets dirty=1.
REQ-019 LOOKUP on miss with victim valid and dirty SHALL go to WRITEBACK; otherwise it SHALL go to FILL; in both cases it records miss.
REQ-020 WRITEBACK SHALL assert, for exactly 1 cycle, mem_clken_out=1, mem_wren_out=1, mem_address_out={victim tag, index}, mem_data_out=victim data, then go to FILL.
REQ-021 FILL SHALL assert, for 1 cycle, mem_clken_out=1, mem_wren_out=0, mem_address_out=latched address, then go to FILL_WAIT.
REQ-022 FILL_WAIT SHALL write mem_q_in into the line, set valid=1 and tag, clear dirty, then return to LOOKUP, which then hits.
REQ-023 RESP SHALL pulse done_out=1 for 1 cycle, with hit_cache_out=~miss; it SHALL then return to IDLE with ready_out=1 in the next cycle.
REQ-024 Latency from the req_in sample edge to the done_out cycle SHALL be: hit 2 cycles, clean miss 5, dirty miss 6.
REQ-025 Outside WRITEBACK and FILL, mem_clken_out and mem_wren_out SHALL be 0.
REQ-026 A write miss SHALL fill first, then merge the write on the second LOOKUP; the line ends dirty=1.
REQ-027 q_out SHALL hold its last value when done_out=0.

Reset
REQ-028 reset_n_in=0 SHALL, at any time including mid-WRITEBACK or mid-FILL, force IDLE and clear all valid/dirty bits.
REQ-029 During reset, outputs SHALL be: ready_out=0, done_out=0, q_out=0, hit_cache_out=0, all mem_* outputs=0, and both counters=0.
REQ-030 An aborted write-back SHALL NOT be retried; ready_out SHALL go to 1 in the first cycle after reset is released.

Configuration
REQ-031 With CACHE_CTRL_STATS_EN defined, hit_count_out and miss_count_out SHALL increment by 1 per completed request (at RESP, according to hit_cache_out) and SHALL saturate at 255.
REQ-032 Without CACHE_CTRL_STATS_EN, both counter outputs SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-033 Scenario: after reset, read addr 5'h03 -> clean miss: FILL drives mem_address_out=5'h03, mem_q_in=8'hA5, done_out at +5 cycles, q_out=8'hA5, hit_cache_out=0.
REQ-034 Scenario: repeat the read of 5'h03 -> done_out at +2 cycles, q_out=8'hA5, hit_cache_out=1, no mem_clken_out pulse.
REQ-035 Scenario: write 8'h3C to 5'h03, then read 5'h07 (same index, tag differs) -> WRITEBACK drives address 5'h03, data 8'h3C, wren=1, then FILL of 5'h07; done_out at +6 cycles.
REQ-036 Scenario: reset_n_in pulsed low during WRITEBACK -> all mem_* outputs are 0 immediately, ready_out=1 the cycle after release, and the next read of 5'h03 misses.
REQ-037 Scenario: req_in held high through a miss -> exactly one request is accepted per IDLE visit, with no duplicate fill.
REQ-038 Scenario: with CACHE_CTRL_STATS_EN, 300 hits -> hit_count_out=255 (saturated); without the macro, both counters read 0.
